// File: rtl/rf_wb_scoreboard.sv
// Writeback arbiter and hazard scoreboard for the integer register file.
// Two writeback sources share the single write port through a round-robin arbiter.
// A per-register busy bit holds back issue on RAW and WAW hazards.
module rf_wb_scoreboard #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_wen,
    output logic            issue_ready,
    input  logic            wb0_valid,
    input  logic [AW-1:0]   wb0_addr,
    input  logic [XLEN-1:0] wb0_data,
    output logic            wb0_ready,
    input  logic            wb1_valid,
    input  logic [AW-1:0]   wb1_addr,
    input  logic [XLEN-1:0] wb1_data,
    output logic            wb1_ready,
    output logic            rf_wen,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] busy_vec,
    output logic            err_spurious
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            last_grant_q, last_grant_d;  // 0 = wb0, 1 = wb1
    logic            rf_wen_q, rf_wen_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            err_q, err_d;

    logic            gnt0, gnt1, gnt_any;
    logic [AW-1:0]   gnt_addr;
    logic [XLEN-1:0] gnt_data;
    logic            issue_fire;

    // Hazard check and round-robin grant selection.
    always_comb begin
        issue_ready = 1'b1;
        if ((issue_rs1 != '0) && busy_q[issue_rs1]) issue_ready = 1'b0;
        if ((issue_rs2 != '0) && busy_q[issue_rs2]) issue_ready = 1'b0;
        if (issue_wen && (issue_rd != '0) && busy_q[issue_rd]) issue_ready = 1'b0;
        issue_fire = issue_valid & issue_ready;

        // On conflict the requester that did not win last time is served.
        gnt0    = wb0_valid & (~wb1_valid | last_grant_q);
        gnt1    = wb1_valid & (~wb0_valid | ~last_grant_q);
        gnt_any = gnt0 | gnt1;
        gnt_addr = gnt1 ? wb1_addr : wb0_addr;
        gnt_data = gnt1 ? wb1_data : wb0_data;
        wb0_ready = gnt0;
        wb1_ready = gnt1;
    end

    // Next-state for scoreboard, write stage, arbiter history and error flag.
    always_comb begin
        busy_d       = busy_q;
        last_grant_d = last_grant_q;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        err_d        = err_q;

        if (gnt_any) begin
            last_grant_d = gnt1;
            rf_wen_d     = (gnt_addr != '0);
            rf_waddr_d   = gnt_addr;
            rf_wdata_d   = gnt_data;
            if ((gnt_addr != '0) && !busy_q[gnt_addr]) err_d = 1'b1;
        end

        // Clear first so that a same-edge set takes priority.
        if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
        if (issue_fire && issue_wen && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // State registers; reset drops any writeback still in the write stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q       <= '0;
            last_grant_q <= 1'b1;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            err_q        <= err_d;
        end
    end

    // Output mapping; x0 never reports busy.
    always_comb begin
        rf_wen       = rf_wen_q;
        rf_waddr     = rf_waddr_q;
        rf_wdata     = rf_wdata_q;
        err_spurious = err_q;
        busy_vec     = {busy_q[NREG-1:1], 1'b0};
    end

endmodule
